// File: rtl/rc_servo_pulse_decoder.sv
// RC servo pulse-width receiver: measures the high time of pwm_i in whole us
// and maps it to an 8-bit position, with glitch rejection and signal-loss flag.
module rc_servo_pulse_decoder #(
    parameter int CLK_DIV      = 10,
    parameter int MIN_US       = 1000,
    parameter int REJECT_LO_US = 500,
    parameter int REJECT_HI_US = 2500,
    parameter int TIMEOUT_US   = 25000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pwm_i,
    output logic [7:0]  pos_o,
    output logic [11:0] width_us_o,
    output logic        valid_o,
    output logic        glitch_o,
    output logic        lost_o
);
    localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W = $clog2(TIMEOUT_US + 1);

    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_DIV - 1);
    localparam logic [11:0]     US_MAX   = 12'hFFF;
    localparam logic [11:0]     MIN_W    = 12'(MIN_US);
    localparam logic [11:0]     LO_W     = 12'(REJECT_LO_US);
    localparam logic [11:0]     HI_W     = 12'(REJECT_HI_US);
    localparam logic [11:0]     SPAN_MAX = 12'd1023;
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_US);

    typedef enum logic [1:0] {IDLE, MEASURE, WAIT_LOW} state_t;

    state_t          state_q, state_d;
    logic            pwm_meta, pwm_sync, pwm_prev;
    logic [1:0]      boot;
    logic            boot_done, rise, fall, tick, overflow, eval_q;
    logic [PS_W-1:0] presc;
    logic [11:0]     us_cnt, span;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      pos_calc;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pwm_meta <= 1'b0;
            pwm_sync <= 1'b0;
            pwm_prev <= 1'b0;
            boot     <= 2'd0;
        end else begin
            pwm_meta <= pwm_i;
            pwm_sync <= pwm_meta;
            pwm_prev <= pwm_sync;
            if (!boot_done) boot <= boot + 2'd1;
        end
    end

    // Edges are masked until the synchronizer and history flop hold real samples.
    assign boot_done = (boot == 2'd3);
    assign rise      = boot_done & pwm_sync & ~pwm_prev;
    assign fall      = boot_done & ~pwm_sync & pwm_prev;
    assign tick      = (presc == PS_LAST);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc  <= '0;
            us_cnt <= '0;
            to_cnt <= '0;
        end else begin
            if (rise || tick) presc <= '0;
            else              presc <= presc + PS_W'(1);

            if (state_q == IDLE && rise)
                us_cnt <= '0;
            else if (state_q == MEASURE && tick && us_cnt != US_MAX)
                us_cnt <= us_cnt + 12'd1;

            if (rise)
                to_cnt <= '0;
            else if (tick && to_cnt != TO_MAX)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (boot == 2'd2 && pwm_sync) state_d = WAIT_LOW;
                else if (rise)                state_d = MEASURE;
            end
            MEASURE: begin
                if (fall)                state_d = IDLE;
                else if (us_cnt > HI_W)  state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!pwm_sync) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign overflow = (state_q == MEASURE) && !fall && (us_cnt > HI_W);

    // Position = clamp(width - MIN_US, 0, 1023) / 4.
    always_comb begin
        span = '0;
        if (us_cnt > MIN_W) span = us_cnt - MIN_W;
    end
    assign pos_calc = (span > SPAN_MAX) ? 8'hFF : span[9:2];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pos_o      <= '0;
            width_us_o <= '0;
            valid_o    <= 1'b0;
            glitch_o   <= 1'b0;
            lost_o     <= 1'b1;
            eval_q     <= 1'b0;
        end else begin
            valid_o  <= 1'b0;
            glitch_o <= 1'b0;
            eval_q   <= (state_q == MEASURE) && fall;
            if (to_cnt == TO_MAX) lost_o <= 1'b1;
            // us_cnt already includes the tick taken on the fall cycle.
            if (eval_q) begin
                if (us_cnt < LO_W || us_cnt > HI_W) begin
                    glitch_o <= 1'b1;
                end else begin
                    width_us_o <= us_cnt;
                    pos_o      <= pos_calc;
                    valid_o    <= 1'b1;
                    lost_o     <= 1'b0;
                end
            end else if (overflow) begin
                glitch_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rc_servo_pulse_decoder.sv
// Self-checking bench for rc_servo_pulse_decoder: directed and random pulses
// compared against a width/position/loss model derived from pulse lengths.
`timescale 1ns/1ps
module tb_rc_servo_pulse_decoder;
    localparam int CLK_DIV    = 2;
    localparam int TIMEOUT_US = 6000;
    localparam int MIN_US     = 1000;
    localparam int LO_US      = 500;
    localparam int HI_US      = 2500;

    logic        clk = 1'b0;
    logic        reset_i, pwm_i;
    logic [7:0]  pos_o;
    logic [11:0] width_us_o;
    logic        valid_o, glitch_o, lost_o;

    rc_servo_pulse_decoder #(
        .CLK_DIV(CLK_DIV), .MIN_US(MIN_US), .REJECT_LO_US(LO_US),
        .REJECT_HI_US(HI_US), .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .pwm_i(pwm_i), .pos_o(pos_o),
        .width_us_o(width_us_o), .valid_o(valid_o), .glitch_o(glitch_o), .lost_o(lost_o)
    );

    always #50 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, n_valid = 0, n_glitch = 0, n_both = 0, glitch_cyc = 0;
    int exp_pos = 0, exp_width = 0, exp_lost = 1;
    int rise_cyc = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (valid_o) n_valid <= n_valid + 1;
        if (glitch_o) begin
            n_glitch   <= n_glitch + 1;
            glitch_cyc <= cyc;
        end
        if (valid_o && glitch_o) n_both <= n_both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int model_pos(input int w);
        int d;
        if (w <= MIN_US) return 0;
        d = w - MIN_US;
        if (d > 1023) d = 1023;
        return d / 4;
    endfunction

    // Caller is positioned just after a negedge; hi/lo are in clock cycles.
    task automatic pulse(input int hi, input int lo);
        pwm_i    = 1'b1;
        rise_cyc = cyc;
        repeat (hi) @(negedge clk);
        pwm_i = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic do_pulse(input string tag, input int hi, input int lo);
        int v0, g0, w;
        bit ok;
        v0 = n_valid;
        g0 = n_glitch;
        w  = hi / CLK_DIV;
        ok = (w >= LO_US) && (w <= HI_US);
        pulse(hi, lo);
        if (ok) begin
            exp_width = w;
            exp_pos   = model_pos(w);
            exp_lost  = 0;
        end
        chk({tag, ".valid"},  n_valid - v0,  ok ? 1 : 0);
        chk({tag, ".glitch"}, n_glitch - g0, ok ? 0 : 1);
        chk({tag, ".width"},  width_us_o,    exp_width);
        chk({tag, ".pos"},    pos_o,         exp_pos);
        chk({tag, ".lost"},   lost_o,        exp_lost);
    endtask

    initial begin
        int v0, g0, dt, hi, lo;
        reset_i = 1'b1;
        pwm_i   = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst.pos", pos_o, 0);
        chk("rst.width", width_us_o, 0);
        chk("rst.valid", valid_o, 0);
        chk("rst.glitch", glitch_o, 0);
        chk("rst.lost", lost_o, 1);
        reset_i = 1'b0;
        repeat (10) @(negedge clk);

        do_pulse("p1500", 1500 * CLK_DIV, 100);
        do_pulse("p1000", 1000 * CLK_DIV, 100);
        do_pulse("p900",  900 * CLK_DIV, 100);
        do_pulse("p2100", 2100 * CLK_DIV, 100);
        do_pulse("p2500", 2500 * CLK_DIV, 100);
        do_pulse("p2600", 2600 * CLK_DIV, 100);
        dt = glitch_cyc - rise_cyc;
        chk("p2600.glitch_at", (dt >= (HI_US + 1) * CLK_DIV) && (dt <= (HI_US + 1) * CLK_DIV + 10), 1);

        do_pulse("p1500b", 1500 * CLK_DIV, 100);
        do_pulse("p300",   300 * CLK_DIV, 100);
        do_pulse("p499",   499 * CLK_DIV, 100);
        do_pulse("p500",   500 * CLK_DIV, 100);
        do_pulse("p1500_partial", 1500 * CLK_DIV + 1, 100);

        // Signal loss: no rising edge for TIMEOUT_US after the last pulse.
        do_pulse("pre_to", 1500 * CLK_DIV, 100);
        repeat (rise_cyc + (TIMEOUT_US - 50) * CLK_DIV - cyc) @(negedge clk);
        chk("to.before", lost_o, 0);
        repeat (70 * CLK_DIV) @(negedge clk);
        chk("to.after", lost_o, 1);
        exp_lost = 1;
        do_pulse("p1200", 1200 * CLK_DIV, 100);

        // Reset mid-pulse, released while pwm_i is still high.
        v0 = n_valid;
        g0 = n_glitch;
        pwm_i = 1'b1;
        repeat (400) @(negedge clk);
        #20 reset_i = 1'b1;
        #5;
        chk("rst_mid.async_pos", pos_o, 0);
        chk("rst_mid.async_lost", lost_o, 1);
        repeat (3) @(negedge clk);
        chk("rst_mid.width", width_us_o, 0);
        exp_pos = 0;
        exp_width = 0;
        exp_lost = 1;
        reset_i = 1'b0;
        repeat (1000) @(negedge clk);
        pwm_i = 1'b0;
        repeat (100) @(negedge clk);
        chk("rst_mid.no_valid", n_valid - v0, 0);
        chk("rst_mid.no_glitch", n_glitch - g0, 0);
        chk("rst_mid.pos", pos_o, 0);
        do_pulse("post_rst_glitch", 300 * CLK_DIV, 100);
        do_pulse("post_rst_1500", 1500 * CLK_DIV, 100);

        for (int i = 0; i < 6; i++) begin
            hi = int'($urandom_range(2750 * CLK_DIV, 250 * CLK_DIV));
            lo = int'($urandom_range(300, 40));
            do_pulse("rand", hi, lo);
        end

        chk("never_both", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
